// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width and Gray/binary conversion helpers shared by both FIFO clock domains
package fifo_pkg;
  localparam int DEF_DEPTH = 8;
  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction
  typedef logic [ptr_bits(DEF_DEPTH):0] ptr_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchroniser for a Gray-coded pointer crossing clock domains
module gray_ptr_sync #(
  parameter int W = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[STAGES-2:0], d};
  assign q = sync[STAGES-1];
endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// fifo_rd_ptr_ctrl: read-domain pointer, empty/almost-empty flags and read strobes for the async FIFO
module fifo_rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_LEVEL = 2,
  localparam int PB = ptr_bits(DEPTH),
  localparam int W = PB + 1
) (
  input  logic         rd_clk,
  input  logic         rd_rst_n,
  input  logic         rd_en,
  input  logic [W-1:0] wr_ptr_gray,
  output logic [W-1:0] rd_ptr,
  output logic [W-1:0] rd_ptr_gray,
  output logic [W-1:0] wr_ptr_rdclk_gray,
  output logic [W-1:0] rd_level,
  output logic         EMPTY,
  output logic         ALMOST_EMPTY,
  output logic         rd_valid,
  output logic         underflow
);
  logic         rd_accept;
  logic [W-1:0] rd_ptr_next, rd_ptr_next_gray, wr_bin, level_next;
  gray_ptr_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync (
    .clk(rd_clk),
    .rst_n(rd_rst_n),
    .d(wr_ptr_gray),
    .q(wr_ptr_rdclk_gray)
  );
  assign rd_accept = rd_en & ~EMPTY;
  assign rd_ptr_next = rd_ptr + W'(rd_accept);
  assign rd_ptr_next_gray = W'(bin2gray(32'(rd_ptr_next)));
  assign wr_bin = W'(gray2bin(32'(wr_ptr_rdclk_gray)));
  assign level_next = wr_bin - rd_ptr_next;
  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      rd_ptr       <= '0;
      rd_ptr_gray  <= '0;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      rd_ptr       <= rd_ptr_next;
      rd_ptr_gray  <= rd_ptr_next_gray;
      rd_level     <= level_next;
      rd_valid     <= rd_accept;
      underflow    <= rd_en & EMPTY;
      EMPTY        <= rd_ptr_next_gray == wr_ptr_rdclk_gray;
      ALMOST_EMPTY <= int'(level_next) <= AE_LEVEL;
    end
endmodule
